grid_row_loader: RTL and testbench

// - Writer side of the grid bank: parses an ASCII puzzle stream ('@'=1, '.'=0, '\n' row end)

---
 rtl/grid_row_loader_pkg.sv | 29 ++
 rtl/grid_row_loader_if.sv | 14 +
 rtl/grid_row_loader.sv | 194 +++++++++++++++++++
 tb/tb_grid_row_loader.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_row_loader_pkg.sv
// Shared definitions for the grid row loader.
// Contents: default grid geometry, the ASCII codes the parser recognises,
// the load FSM state encoding and the error code encoding that the loader
// reports on err_code.
package grid_row_loader_pkg;

    localparam int GRID_WIDTH  = 140;
    localparam int GRID_HEIGHT = 140;

    localparam logic [7:0] CHAR_AT  = 8'h40;  // '@' -> cell bit 1
    localparam logic [7:0] CHAR_DOT = 8'h2E;  // '.' -> cell bit 0
    localparam logic [7:0] CHAR_LF  = 8'h0A;  // row terminator
    localparam logic [7:0] CHAR_CR  = 8'h0D;  // tolerated, ignored

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } load_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_CHAR  = 2'd1,
        ERR_BAD_LEN   = 2'd2,
        ERR_EARLY_END = 2'd3
    } err_code_e;

endpackage

// File: rtl/grid_row_loader_if.sv
// Byte stream into the grid row loader.
// Signals: s_valid (byte valid), s_ready (byte taken when s_valid & s_ready),
//          s_data (ASCII byte), s_last (final byte of the file, qualified by
//          the handshake).
// Modports: master = stream source, slave = loader.
interface grid_row_loader_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/grid_row_loader.sv
// Writer side of the grid bank. Parses an ASCII puzzle stream ('@' = 1,
// '.' = 0, '\n' ends a row, '\r' ignored, blank lines ignored) and writes one
// packed WIDTH-bit row per line into the bank. First character of a line
// lands in bit WIDTH-1.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a load (honoured in IDLE, DONE, ERROR)
//   s_if          byte stream slave (s_valid/s_ready/s_data/s_last)
//   wr_en         one-cycle bank write strobe
//   wr_addr       row index of the write
//   wr_data       packed row of the write
//   busy          high while loading
//   done, error   completion / fault status levels
//   err_code      0 none, 1 bad char, 2 bad row length, 3 early end
//   cell_count    number of '@' written
//
// Build option: define GRID_LOADER_POPCOUNT_EN to accumulate cell_count from
// each committed row; without it cell_count is constant zero.
module grid_row_loader
    import grid_row_loader_pkg::*;
#(
    parameter  int WIDTH  = GRID_WIDTH,
    parameter  int HEIGHT = GRID_HEIGHT,
    localparam int AW     = $clog2(HEIGHT),
    localparam int CW     = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    grid_row_loader_if.slave   s_if,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [WIDTH-1:0]   wr_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output err_code_e          err_code,
    output logic [14:0]        cell_count
);

    load_state_e        state;
    logic               s_ready_q;
    logic               fin;        // last row committed, write in flight
    logic [CW-1:0]      col;
    logic [AW-1:0]      row;
    logic [WIDTH-1:0]   shreg;

    logic               hs;
    logic               is_data;
    logic               cell_bit;
    logic               col_full;
    logic               last_row;
    logic               do_shift;
    logic               do_commit;
    err_code_e          byte_err;
    logic [WIDTH-1:0]   row_bits;
    logic               start_load;
    logic               commit_fire;

    assign s_if.s_ready = s_ready_q;
    assign hs           = s_ready_q & s_if.s_valid;
    assign start_load   = start & (state != ST_LOAD);
    assign commit_fire  = hs & do_commit;

    // Classify the byte on the bus. Evaluated every cycle; only acted on when
    // the handshake fires.
    always_comb begin
        is_data   = (s_if.s_data == CHAR_AT) || (s_if.s_data == CHAR_DOT);
        cell_bit  = (s_if.s_data == CHAR_AT);
        col_full  = (col == CW'(WIDTH));
        last_row  = (row == AW'(HEIGHT - 1));
        do_shift  = 1'b0;
        do_commit = 1'b0;
        byte_err  = ERR_NONE;

        if (is_data) begin
            if (col_full) begin
                byte_err = ERR_BAD_LEN;
            end else begin
                do_shift = 1'b1;
                // A file may end right after the last cell with no newline.
                do_commit = s_if.s_last && last_row && (col == CW'(WIDTH - 1));
            end
        end else if (s_if.s_data == CHAR_LF) begin
            if (col_full)
                do_commit = 1'b1;
            else if (col != '0)
                byte_err = ERR_BAD_LEN;
        end else if (s_if.s_data != CHAR_CR) begin
            byte_err = ERR_BAD_CHAR;
        end

        // Early end has the lowest priority; a commit on this same byte still
        // happens, it just does not complete the grid.
        if (byte_err == ERR_NONE && s_if.s_last && !(do_commit && last_row))
            byte_err = ERR_EARLY_END;

        row_bits = do_shift ? {shreg[WIDTH-2:0], cell_bit} : shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            s_ready_q <= 1'b0;
            fin       <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            col       <= '0;
            row       <= '0;
            shreg     <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_code  <= ERR_NONE;
                        fin       <= 1'b0;
                        col       <= '0;
                        row       <= '0;
                        shreg     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (fin) begin
                        // Final write strobe is on the bank this cycle.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fin   <= 1'b0;
                    end else if (hs) begin
                        if (do_commit) begin
                            wr_en   <= 1'b1;
                            wr_addr <= row;
                            wr_data <= row_bits;
                            col     <= '0;
                            row     <= row + 1'b1;
                        end else if (do_shift) begin
                            shreg <= row_bits;
                            col   <= col + 1'b1;
                        end

                        if (byte_err != ERR_NONE) begin
                            state     <= ST_ERROR;
                            s_ready_q <= 1'b0;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_code  <= byte_err;
                        end else if (do_commit && last_row) begin
                            // Stop consuming; trailing bytes stay on the bus.
                            s_ready_q <= 1'b0;
                            fin       <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GRID_LOADER_POPCOUNT_EN
    logic [14:0] row_pop;

    always_comb begin
        row_pop = '0;
        for (int i = 0; i < WIDTH; i++)
            row_pop = row_pop + 15'(row_bits[i]);
    end

    // Updated on the same edge that raises wr_en, so the total is final by
    // the time done rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cell_count <= '0;
        else if (start_load)
            cell_count <= '0;
        else if (commit_fire)
            cell_count <= cell_count + row_pop;
    end
`else
    assign cell_count = '0;
`endif

endmodule

// File: tb/tb_grid_row_loader.sv
// Self-checking bench for grid_row_loader at WIDTH=4, HEIGHT=3.
// Streams directed and randomly generated ASCII grids through the byte
// interface and compares the bank writes and final status against a
// line-oriented reference model kept here.
module tb_grid_row_loader;
    import grid_row_loader_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    grid_row_loader_if bus();

    logic           wr_en;
    logic [1:0]     wr_addr;
    logic [W-1:0]   wr_data;
    logic           busy, done, error;
    err_code_e      err_code;
    logic [14:0]    cell_count;

    grid_row_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_if       (bus),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .cell_count (cell_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observed bank writes
    int act_a[$];
    int act_d[$];
    always @(negedge clk) begin
        if (wr_en) begin
            act_a.push_back(int'(wr_addr));
            act_d.push_back(int'(wr_data));
        end
    end

    // Reference model state: expected writes, 0 running / 1 done / 2 error
    int exp_a[$];
    int exp_d[$];
    int exp_st, exp_err, exp_cnt;
    int m_bits[$];

    task automatic model_emit(input int r);
        int v = 0;
        for (int k = 0; k < W; k++) begin
            if (m_bits[k] != 0) v = v + (1 << (W - 1 - k));
            exp_cnt += m_bits[k];
        end
        exp_a.push_back(r);
        exp_d.push_back(v);
        m_bits.delete();
    endtask

    // Walk the file line by line as the loader's contract describes it.
    task automatic model(input string s, input int li);
        int r = 0;
        exp_a.delete(); exp_d.delete(); m_bits.delete();
        exp_st = 0; exp_err = 0; exp_cnt = 0;
        for (int i = 0; i < s.len() && exp_st == 0; i++) begin
            byte c;
            bit  lastb;
            int  e;
            c = s[i];
            lastb = (i == li);
            e = 0;
            if (c == "@" || c == ".") begin
                if (m_bits.size() == W) e = 2;
                else begin
                    m_bits.push_back(c == "@" ? 1 : 0);
                    if (lastb && m_bits.size() == W && r == H - 1) begin
                        model_emit(r);
                        exp_st = 1;
                    end
                end
            end else if (c == "\n") begin
                if (m_bits.size() == W) begin
                    model_emit(r);
                    r++;
                    if (r == H) exp_st = 1;
                end else if (m_bits.size() > 0) e = 2;
            end else if (c != "\r") begin
                e = 1;
            end
            if (e == 0 && lastb && exp_st == 0) e = 3;
            if (e != 0) begin
                exp_st = 2;
                exp_err = e;
            end
        end
`ifndef GRID_LOADER_POPCOUNT_EN
        exp_cnt = 0;
`endif
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feed bytes with random idle gaps until the stream ends or the loader
    // stops accepting (done/error). Every wait is bounded.
    task automatic drive(input string s, input int li, input int gap_max,
                         input bit wait_end, input string nm);
        bit stop = 0;
        for (int i = 0; i < s.len() && !stop; i++) begin
            bit acc = 0;
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
            bus.s_valid = 1'b1;
            bus.s_data  = s[i];
            bus.s_last  = (i == li);
            for (int t = 0; t < 40 && !acc && !stop; t++) begin
                @(negedge clk);
                if (bus.s_ready) acc = 1;
                else if (done || error) stop = 1;
                @(posedge clk); #1;
            end
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            if (!acc && !stop) begin
                n_cmp++; n_bad++;
                $display("FAIL %s handshake timeout at byte %0d: s_ready stuck low, want accept", nm, i);
                stop = 1;
            end
        end
        if (wait_end) begin
            for (int t = 0; t < 20 && !(done || error); t++) begin @(posedge clk); #1; end
            n_cmp++;
            if (!(done || error)) begin
                n_bad++;
                $display("FAIL %s end timeout: done=%0b error=%0b, want one set", nm, done, error);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
        #2;
        n_cmp++;
        if ({bus.s_ready, wr_en, busy, done, error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset ctrl: got %b want 00000", {bus.s_ready, wr_en, busy, done, error});
        end
        n_cmp++;
        if (err_code !== ERR_NONE || wr_addr !== '0 || wr_data !== '0 || cell_count !== '0) begin
            n_bad++;
            $display("FAIL reset data: err=%0d addr=%0d data=%b cnt=%0d want all 0",
                     err_code, wr_addr, wr_data, cell_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        n_cmp++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle no start: busy=%0b s_ready=%0b want 0 0", busy, bus.s_ready);
        end
    endtask

    task automatic test_directed();
        string ds[8];
        int    dl[8];
        ds[0] = "@.@@\n....\n@@@@\n";             dl[0] = 14;
        ds[1] = "@.@@\r\n....\r\n\n@@@@\r\n";     dl[1] = 18;
        ds[2] = "@.@@\n@x";                       dl[2] = -1;
        ds[3] = "@.@\n";                          dl[3] = -1;
        ds[4] = "@.@@@";                          dl[4] = -1;
        ds[5] = "@.@@\n....\n";                   dl[5] = 9;
        ds[6] = "@.@@\n....\n@@@@";               dl[6] = 13;
        ds[7] = "@.@@\n....\n@@@@\n\n";           dl[7] = 15;
        for (int c = 0; c < 8; c++) begin
            string nm;
            nm = $sformatf("directed%0d", c);
            model(ds[c], dl[c]);
            act_a.delete(); act_d.delete();
            pulse_start();
            n_cmp++;
            if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s after start: busy=%0b s_ready=%0b want 1 1", nm, busy, bus.s_ready);
            end
            drive(ds[c], dl[c], 2, 1, nm);
            repeat (2) @(posedge clk);
            n_cmp++;
            if (act_a.size() != exp_a.size()) begin
                n_bad++;
                $display("FAIL %s write count: got %0d want %0d", nm, act_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < act_a.size(); k++) begin
                n_cmp++;
                if (act_a[k] !== exp_a[k] || act_d[k] !== exp_d[k]) begin
                    n_bad++;
                    $display("FAIL %s write%0d: got %0d:%h want %0d:%h", nm, k, act_a[k], act_d[k], exp_a[k], exp_d[k]);
                end
            end
            n_cmp++;
            if ({done, error} !== {exp_st == 1, exp_st == 2} || err_code !== 2'(exp_err) ||
                cell_count !== 15'(exp_cnt) || bus.s_ready !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s status: done=%0b error=%0b code=%0d cnt=%0d rdy=%0b busy=%0b want done=%0b error=%0b code=%0d cnt=%0d rdy=0 busy=0",
                         nm, done, error, err_code, cell_count, bus.s_ready, busy,
                         exp_st == 1, exp_st == 2, exp_err, exp_cnt);
            end
        end
    endtask

    task automatic gen(output string s, output int li);
        string ch;
        bit implicit_end;
        int kind;
        s = "";
        implicit_end = ($urandom_range(3, 0) == 0);
        for (int r = 0; r < H; r++) begin
            if (r > 0 && $urandom_range(3, 0) == 0) s = {s, "\n"};
            for (int c = 0; c < W; c++) begin
                ch = $urandom_range(1, 0) ? "@" : ".";
                s = {s, ch};
            end
            if (r < H - 1 || !implicit_end) begin
                ch = $urandom_range(1, 0) ? "\r\n" : "\n";
                s = {s, ch};
            end
        end
        if (!implicit_end && $urandom_range(3, 0) == 0) s = {s, "\n"};
        li = s.len() - 1;
        kind = $urandom_range(5, 0);
        if (kind == 0) s.putc($urandom_range(s.len() - 1, 0), "x");
        else if (kind == 1) begin
            int idx;
            idx = $urandom_range(s.len() - 2, 1);
            s = {s.substr(0, idx - 1), s.substr(idx + 1, s.len() - 1)};
            li = s.len() - 1;
        end else if (kind == 2) li = $urandom_range(s.len() - 2, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            string s, nm;
            int li;
            gen(s, li);
            nm = $sformatf("random%0d", it);
            model(s, li);
            act_a.delete(); act_d.delete();
            pulse_start();
            drive(s, li, 2, 1, nm);
            repeat (2) @(posedge clk);
            n_cmp++;
            if (act_a.size() != exp_a.size()) begin
                n_bad++;
                $display("FAIL %s write count: got %0d want %0d", nm, act_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < act_a.size(); k++) begin
                n_cmp++;
                if (act_a[k] !== exp_a[k] || act_d[k] !== exp_d[k]) begin
                    n_bad++;
                    $display("FAIL %s write%0d: got %0d:%h want %0d:%h", nm, k, act_a[k], act_d[k], exp_a[k], exp_d[k]);
                end
            end
            n_cmp++;
            if ({done, error} !== {exp_st == 1, exp_st == 2} || err_code !== 2'(exp_err) ||
                cell_count !== 15'(exp_cnt)) begin
                n_bad++;
                $display("FAIL %s status: done=%0b error=%0b code=%0d cnt=%0d want done=%0b error=%0b code=%0d cnt=%0d",
                         nm, done, error, err_code, cell_count, exp_st == 1, exp_st == 2, exp_err, exp_cnt);
            end
        end
    endtask

    // Gapless streams, restarted straight out of DONE.
    task automatic test_back_to_back();
        string s;
        s = "@@.@\r\n.@..\n\n@@.@\n";
        for (int rep = 0; rep < 2; rep++) begin
            model(s, s.len() - 1);
            act_a.delete(); act_d.delete();
            pulse_start();
            n_cmp++;
            if (done !== 1'b0 || error !== 1'b0 || err_code !== ERR_NONE || cell_count !== '0) begin
                n_bad++;
                $display("FAIL b2b%0d restart clear: done=%0b error=%0b code=%0d cnt=%0d want 0 0 0 0",
                         rep, done, error, err_code, cell_count);
            end
            drive(s, s.len() - 1, 0, 1, "b2b");
            repeat (2) @(posedge clk);
            n_cmp++;
            if (act_a.size() != exp_a.size()) begin
                n_bad++;
                $display("FAIL b2b%0d write count: got %0d want %0d", rep, act_a.size(), exp_a.size());
            end
            for (int k = 0; k < exp_a.size() && k < act_a.size(); k++) begin
                n_cmp++;
                if (act_a[k] !== exp_a[k] || act_d[k] !== exp_d[k]) begin
                    n_bad++;
                    $display("FAIL b2b%0d write%0d: got %0d:%h want %0d:%h", rep, k, act_a[k], act_d[k], exp_a[k], exp_d[k]);
                end
            end
            n_cmp++;
            if (done !== 1'b1 || cell_count !== 15'(exp_cnt)) begin
                n_bad++;
                $display("FAIL b2b%0d status: done=%0b cnt=%0d want 1 %0d", rep, done, cell_count, exp_cnt);
            end
        end
    endtask

    task automatic test_rst_mid();
        string s;
        act_a.delete(); act_d.delete();
        pulse_start();
        drive("@.@@\n@.", -1, 1, 0, "rst_mid");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || bus.s_ready !== 1'b0 || wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid async: busy=%0b s_ready=%0b wr_en=%0b want 0 0 0", busy, bus.s_ready, wr_en);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        n_cmp++;
        if (act_a.size() != 1) begin
            n_bad++;
            $display("FAIL rst_mid writes before restart: got %0d want 1", act_a.size());
        end
        s = "@.@@\n....\n@@@@\n";
        model(s, s.len() - 1);
        act_a.delete(); act_d.delete();
        pulse_start();
        drive(s, s.len() - 1, 1, 1, "rst_mid");
        repeat (2) @(posedge clk);
        n_cmp++;
        if (act_a.size() != exp_a.size()) begin
            n_bad++;
            $display("FAIL rst_mid write count: got %0d want %0d", act_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < act_a.size(); k++) begin
            n_cmp++;
            if (act_a[k] !== exp_a[k] || act_d[k] !== exp_d[k]) begin
                n_bad++;
                $display("FAIL rst_mid write%0d: got %0d:%h want %0d:%h", k, act_a[k], act_d[k], exp_a[k], exp_d[k]);
            end
        end
        n_cmp++;
        if (done !== 1'b1 || error !== 1'b0 || cell_count !== 15'(exp_cnt)) begin
            n_bad++;
            $display("FAIL rst_mid status: done=%0b error=%0b cnt=%0d want 1 0 %0d", done, error, cell_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
